// File: rtl/stream_chk_pkg.sv
// Shared types and constants for the stream sink checker and its LFSR throttle.
package stream_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    localparam int          ERR_W             = 16;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reload; shared by stream sink and source.
module lfsr16
    import stream_chk_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Next-state: reload wins over advance
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (en) begin
            q_d = lfsr_step(q_q);
        end else begin
            q_d = q_q;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/stream_sink_check.sv
// Valid/ready stream consumer that checks each accepted word against a loaded
// expected table, counting mismatches and capturing the first failing index.
module stream_sink_check
    import stream_chk_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          NUMVALS   = 2340,
    parameter int          ADDRW     = 12,
    parameter int          THROTTLE  = 1,
    parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] s_data_in_y,
    input  logic                    s_valid_y,
    output logic                    s_ready_y,
    input  logic                    ld_en,
    input  logic [ADDRW-1:0]        ld_addr,
    input  logic [WIDTH-1:0]        ld_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ERR_W-1:0]        err_count,
    output logic [ADDRW-1:0]        first_err_idx,
    output logic                    first_err_vld
);

    localparam logic [ADDRW-1:0] LAST_IDX  = ADDRW'(NUMVALS - 1);
    localparam logic [ADDRW:0]   TBL_DEPTH = (ADDRW + 1)'(NUMVALS);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    logic signed [WIDTH-1:0] tbl_q [0:NUMVALS-1];

    state_e                  state_q, state_d;
    logic [ADDRW-1:0]        idx_q, idx_d;
    logic [ERR_W-1:0]        err_q, err_d;
    logic [ADDRW-1:0]        ferr_idx_q, ferr_idx_d;
    logic                    ferr_vld_q, ferr_vld_d;
    logic                    cmp_vld_q, cmp_vld_d;
    logic signed [WIDTH-1:0] cmp_data_q, cmp_data_d;
    logic signed [WIDTH-1:0] cmp_exp_q, cmp_exp_d;
    logic [ADDRW-1:0]        cmp_idx_q, cmp_idx_d;

    logic [15:0] lfsr_s;
    logic        unused_lfsr_s;
    logic        run_s;
    logic        xfer_s;
    logic        start_ok_s;

    assign run_s         = (state_q == RUN);
    assign s_ready_y     = run_s && ((THROTTLE != 0) ? lfsr_s[0] : 1'b1);
    assign xfer_s        = s_valid_y && s_ready_y;
    assign start_ok_s    = start && ((state_q == IDLE) || (state_q == DONE));
    assign unused_lfsr_s = ^lfsr_s[15:1];

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (run_s),
        .load  (start_ok_s),
        .seed  (LFSR_SEED),
        .q     (lfsr_s)
    );

    // Expected table: written only while idle, out-of-range addresses dropped
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && ld_en && ({1'b0, ld_addr} < TBL_DEPTH)) begin
            tbl_q[ld_addr] <= ld_data;
        end
    end

    // FSM next state, compare retirement, capture of new transfers
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_d      = err_q;
        ferr_idx_d = ferr_idx_q;
        ferr_vld_d = ferr_vld_q;
        cmp_vld_d  = xfer_s;
        cmp_data_d = cmp_data_q;
        cmp_exp_d  = cmp_exp_q;
        cmp_idx_d  = cmp_idx_q;

        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = (xfer_s && (idx_q == LAST_IDX)) ? DRAIN : RUN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = start ? RUN : DONE;
            default: state_d = IDLE;
        endcase

        if (cmp_vld_q && (cmp_data_q != cmp_exp_q)) begin
            err_d = (err_q == ERR_MAX) ? err_q : (err_q + 16'd1);
            if (!ferr_vld_q) begin
                ferr_idx_d = cmp_idx_q;
                ferr_vld_d = 1'b1;
            end else begin
                ferr_idx_d = ferr_idx_q;
            end
        end else begin
            err_d = err_q;
        end

        if (xfer_s) begin
            cmp_data_d = s_data_in_y;
            cmp_exp_d  = tbl_q[idx_q];
            cmp_idx_d  = idx_q;
            idx_d      = idx_q + {{(ADDRW-1){1'b0}}, 1'b1};
        end else begin
            idx_d = idx_q;
        end

        // A new run discards previous results; no compare is pending in IDLE/DONE
        if (start_ok_s) begin
            idx_d      = '0;
            err_d      = '0;
            ferr_idx_d = '0;
            ferr_vld_d = 1'b0;
            cmp_vld_d  = 1'b0;
        end else begin
            cmp_vld_d = xfer_s;
        end
    end

    // Control and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            err_q      <= '0;
            ferr_idx_q <= '0;
            ferr_vld_q <= 1'b0;
            cmp_vld_q  <= 1'b0;
            cmp_data_q <= '0;
            cmp_exp_q  <= '0;
            cmp_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            ferr_idx_q <= ferr_idx_d;
            ferr_vld_q <= ferr_vld_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_data_q <= cmp_data_d;
            cmp_exp_q  <= cmp_exp_d;
            cmp_idx_q  <= cmp_idx_d;
        end
    end

    assign busy          = (state_q == RUN) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign pass          = done && (err_q == '0);
    assign err_count     = err_q;
    assign first_err_idx = ferr_idx_q;
    assign first_err_vld = ferr_vld_q;

endmodule
